// File: rtl/phase_fifo_if.sv
// Handshake bundle for phase_fifo: write port, show-ahead read port and status.
// The master modport is the producer/consumer side; the slave modport is the FIFO.
interface phase_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  logic                         wr_valid;
  logic                         wr_ready;
  logic [WIDTH-1:0]             wr_data;
  logic                         rd_valid;
  logic                         rd_ready;
  logic [WIDTH-1:0]             rd_data;
  logic [$clog2(DEPTH+1)-1:0]   level;
  logic                         full;
  logic                         empty;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, level, full, empty
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, level, full, empty
  );
endinterface

// File: rtl/phase_fifo.sv
// Synchronous FIFO using wrap-phase pointers to tell full from empty.
// Show-ahead read, no write-through bypass, status derived from registered state only.
module phase_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  input logic         srst,
  phase_fifo_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic             wph_q, wph_d, rph_q, rph_d;
  logic             ptr_eq, full_w, empty_w, push, pop;
  logic [LvlW-1:0]  wptr_l, rptr_l;

  assign ptr_eq  = (wptr_q == rptr_q);
  assign empty_w = ptr_eq & (wph_q == rph_q);
  assign full_w  = ptr_eq & (wph_q != rph_q);

  // srst wins over any handshake in the same cycle, so it also blocks the write.
  assign push = bus.wr_valid & ~full_w & ~srst;
  assign pop  = bus.rd_ready & ~empty_w & ~srst;

  always_comb begin
    wptr_d = wptr_q;
    wph_d  = wph_q;
    rptr_d = rptr_q;
    rph_d  = rph_q;
    if (srst) begin
      wptr_d = '0;
      wph_d  = 1'b0;
      rptr_d = '0;
      rph_d  = 1'b0;
    end else begin
      if (push) begin
        if (wptr_q == PtrMax) begin
          wptr_d = '0;
          wph_d  = ~wph_q;
        end else begin
          wptr_d = wptr_q + PtrW'(1);
        end
      end
      if (pop) begin
        if (rptr_q == PtrMax) begin
          rptr_d = '0;
          rph_d  = ~rph_q;
        end else begin
          rptr_d = rptr_q + PtrW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      wph_q  <= 1'b0;
      rptr_q <= '0;
      rph_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      wph_q  <= wph_d;
      rptr_q <= rptr_d;
      rph_q  <= rph_d;
    end
  end

  // Storage is deliberately left out of both resets.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= bus.wr_data;
    end
  end

  assign wptr_l = LvlW'(wptr_q);
  assign rptr_l = LvlW'(rptr_q);

  assign bus.wr_ready = ~full_w;
  assign bus.rd_valid = ~empty_w;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.rd_data  = mem_q[rptr_q];
  assign bus.level    = (wph_q == rph_q) ? (wptr_l - rptr_l)
                                         : (LvlW'(DEPTH) - rptr_l + wptr_l);
endmodule

// File: tb/tb_phase_fifo.sv
// Bench for phase_fifo: DEPTH=4 and DEPTH=3 instances share stimulus and are
// checked against queue-based models plus a hand-derived vector table.
module tb_phase_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic srst = 1'b0;
  always #5 clk = ~clk;

  phase_fifo_if #(.WIDTH(8), .DEPTH(4)) b4 ();
  phase_fifo_if #(.WIDTH(8), .DEPTH(3)) b3 ();

  phase_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo4 (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (srst),
    .bus   (b4)
  );

  phase_fifo #(.WIDTH(8), .DEPTH(3)) u_fifo3 (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (srst),
    .bus   (b3)
  );

  typedef struct {
    bit         wv;
    logic [7:0] wd;
    bit         rr;
    int         lvl;
    bit         fl;
    bit         em;
    logic [7:0] rd;
  } vec_t;

  vec_t       tbl[10];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] q4[$];
  logic [7:0] q3[$];
  bit         cur_wv, cur_rr, cur_sr;
  logic [7:0] cur_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("level4", 32'(b4.level), 32'(q4.size()));
    chk("full4", 32'(b4.full), 32'(q4.size() == 4));
    chk("empty4", 32'(b4.empty), 32'(q4.size() == 0));
    chk("wr_ready4", 32'(b4.wr_ready), 32'(q4.size() < 4));
    chk("rd_valid4", 32'(b4.rd_valid), 32'(q4.size() > 0));
    if (q4.size() > 0) chk("rd_data4", 32'(b4.rd_data), 32'(q4[0]));
    chk("level3", 32'(b3.level), 32'(q3.size()));
    chk("full3", 32'(b3.full), 32'(q3.size() == 3));
    chk("empty3", 32'(b3.empty), 32'(q3.size() == 0));
    chk("wr_ready3", 32'(b3.wr_ready), 32'(q3.size() < 3));
    chk("rd_valid3", 32'(b3.rd_valid), 32'(q3.size() > 0));
    if (q3.size() > 0) chk("rd_data3", 32'(b3.rd_data), 32'(q3[0]));
  endtask

  task automatic drive(input bit wv, input logic [7:0] wd, input bit rr, input bit sr);
    cur_wv = wv;
    cur_wd = wd;
    cur_rr = rr;
    cur_sr = sr;
    b4.wr_valid = wv;
    b4.wr_data  = wd;
    b4.rd_ready = rr;
    b3.wr_valid = wv;
    b3.wr_data  = wd;
    b3.rd_ready = rr;
    srst        = sr;
  endtask

  // Model of one clock edge: occupancy before the edge decides accept/offer.
  task automatic model_edge();
    bit pop4, push4, pop3, push3;
    if (cur_sr) begin
      q4.delete();
      q3.delete();
    end else begin
      pop4  = (q4.size() > 0) && cur_rr;
      push4 = (q4.size() < 4) && cur_wv;
      pop3  = (q3.size() > 0) && cur_rr;
      push3 = (q3.size() < 3) && cur_wv;
      if (pop4) void'(q4.pop_front());
      if (push4) q4.push_back(cur_wd);
      if (pop3) void'(q3.pop_front());
      if (push3) q3.push_back(cur_wd);
    end
  endtask

  task automatic step(input bit wv, input logic [7:0] wd, input bit rr, input bit sr);
    drive(wv, wd, rr, sr);
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    // DEPTH=4 expectations (pre-edge state) for fill, overflow attempt, full push+pop, drain.
    tbl[0] = '{1'b1, 8'h11, 1'b0, 0, 1'b0, 1'b1, 8'h00};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1, 1'b0, 1'b0, 8'h11};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 2, 1'b0, 1'b0, 8'h11};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 3, 1'b0, 1'b0, 8'h11};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 4, 1'b1, 1'b0, 8'h11};
    tbl[5] = '{1'b1, 8'h66, 1'b1, 4, 1'b1, 1'b0, 8'h11};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0, 8'h22};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 8'h33};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h44};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'h00};

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    check_all();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].wv, tbl[i].wd, tbl[i].rr, 1'b0);
      #1;
      chk("tbl_level", 32'(b4.level), 32'(tbl[i].lvl));
      chk("tbl_full", 32'(b4.full), 32'(tbl[i].fl));
      chk("tbl_empty", 32'(b4.empty), 32'(tbl[i].em));
      if (!tbl[i].em) chk("tbl_rd_data", 32'(b4.rd_data), 32'(tbl[i].rd));
      check_all();
      @(posedge clk);
      model_edge();
      #1;
    end

    // Steady push+pop from level 2 so both pointers wrap repeatedly.
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Synchronous clear at level 3 with both handshakes active.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h01 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    q4.delete();
    q3.delete();
    #1;
    chk("arst_empty4", 32'(b4.empty), 32'd1);
    chk("arst_level4", 32'(b4.level), 32'd0);
    check_all();
    #7;
    rst_n = 1'b1;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    #1;
    chk("arst_rd_after_push", 32'(b4.rd_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic: write-heavy, then read-heavy, then balanced, rare srst.
    for (int i = 0; i < 450; i++) begin
      bit wv, rr, sr;
      if (i < 150) begin
        wv = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 3) == 0);
      end else if (i < 300) begin
        wv = ($urandom_range(0, 3) == 0);
        rr = ($urandom_range(0, 3) != 0);
      end else begin
        wv = $urandom_range(0, 1) == 1;
        rr = $urandom_range(0, 1) == 1;
      end
      sr = ($urandom_range(0, 39) == 0);
      step(wv, 8'($urandom), rr, sr);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
